mat_vec_mult_seq: RTL and testbench

//  Consumes a parallel signed matrix M[SIZE_A][SIZE_B], as produced by the file-backed matrix

---
 rtl/fecg_mat_pkg.sv | 14 +
 rtl/sat_shift.sv | 29 ++
 rtl/mat_vec_mult_seq.sv | 174 +++++++++++++++++
 tb/tb_mat_vec_mult_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fecg_mat_pkg.sv
// rtl/fecg_mat_pkg.sv - shared types and width helpers for the fetal-ECG matrix datapath
package fecg_mat_pkg;

    typedef enum logic [2:0] {IDLE, MAC, SAT, OUT, DONE} mvm_state_t;

    function automatic int acc_width(input int bits, input int size_b);
        return 2 * bits + $clog2(size_b) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_shift.sv
// rtl/sat_shift.sv - arithmetic right shift by FRAC then clamp into a narrower signed range
module sat_shift #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int FRAC  = 0
) (
    input  logic signed [IN_W-1:0]  data_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    logic signed [IN_W-1:0]   shifted;
    logic        [IN_W-OUT_W:0] top;

    // The value fits when every bit from the output sign bit upward agrees.
    always_comb begin
        shifted = data_i >>> FRAC;
        top     = shifted[IN_W-1:OUT_W-1];
        sat_o   = !((&top) || !(|top));
        if (!sat_o) begin
            data_o = shifted[OUT_W-1:0];
        end else if (top[IN_W-OUT_W]) begin
            data_o = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            data_o = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mat_vec_mult_seq.sv
// rtl/mat_vec_mult_seq.sv - y = M*x on one shared MAC, results streamed row by row
module mat_vec_mult_seq
    import fecg_mat_pkg::*;
#(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int BITS   = 64,
    parameter int FRAC   = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [SIZE_A*SIZE_B*BITS-1:0]     in_matrix,
    input  logic [SIZE_B*BITS-1:0]            in_vector,
    input  logic                              start,
    output logic                              busy,
    output logic signed [BITS-1:0]            out_data,
    output logic [idx_width(SIZE_A)-1:0]      out_index,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sat,
    output logic                              done
);

    localparam int ACC_W = acc_width(BITS, SIZE_B);
    localparam int RW    = idx_width(SIZE_A);
    localparam int CW    = idx_width(SIZE_B);

    mvm_state_t state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic signed [BITS-1:0]  x_q [SIZE_B];
    logic signed [BITS-1:0]  x_d [SIZE_B];
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    valid_q, valid_d, last_q, last_d, sat_q, sat_d;
    logic signed [BITS-1:0]  data_q, data_d;
    logic [RW-1:0]           index_q, index_d;

    logic signed [BITS-1:0]   m_arr [SIZE_A][SIZE_B];
    logic signed [BITS-1:0]   m_elem, x_elem;
    logic signed [2*BITS-1:0] m_ext, x_ext, prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [BITS-1:0]   sat_data;
    logic                     sat_flag;

    for (genvar r = 0; r < SIZE_A; r++) begin : g_row
        for (genvar c = 0; c < SIZE_B; c++) begin : g_col
            assign m_arr[r][c] = in_matrix[(r*SIZE_B+c)*BITS +: BITS];
        end
    end

    // Operands are widened before the multiply so the full product is kept.
    always_comb begin
        m_elem   = m_arr[row_q][col_q];
        x_elem   = x_q[col_q];
        m_ext    = {{BITS{m_elem[BITS-1]}}, m_elem};
        x_ext    = {{BITS{x_elem[BITS-1]}}, x_elem};
        prod     = m_ext * x_ext;
        prod_ext = {{(ACC_W-2*BITS){prod[2*BITS-1]}}, prod};
    end

    sat_shift #(.IN_W(ACC_W), .OUT_W(BITS), .FRAC(FRAC)) u_sat (
        .data_i(acc_q),
        .data_o(sat_data),
        .sat_o (sat_flag)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        row_d   = row_q;
        col_d   = col_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        last_d  = last_q;
        sat_d   = sat_q;
        data_d  = data_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < SIZE_B; i++) begin
                        x_d[i] = in_vector[i*BITS +: BITS];
                    end
                    row_d   = '0;
                    col_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                if (col_q == CW'(SIZE_B-1)) begin
                    col_d   = '0;
                    state_d = SAT;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            SAT: begin
                data_d  = sat_data;
                sat_d   = sat_flag;
                index_d = row_q;
                last_d  = (row_q == RW'(SIZE_A-1));
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        col_d   = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            for (int i = 0; i < SIZE_B; i++) begin
                x_q[i] <= '0;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
            data_q  <= data_d;
            index_q <= index_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_sat   = sat_q;
    assign out_data  = data_q;
    assign out_index = index_q;

endmodule

// File: tb/tb_mat_vec_mult_seq.sv
// tb/tb_mat_vec_mult_seq.sv - directed bench for mat_vec_mult_seq with a behavioural reference model
module tb_mat_vec_mult_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Index 0: BITS=16 FRAC=0, 1: BITS=8 FRAC=0, 2: BITS=16 FRAC=1; all 2x3.
    logic [2:0]  start, out_ready, busy, out_valid, out_last, out_sat, done, out_index;
    logic [15:0] od16, odf;
    logic [7:0]  od8;
    logic [95:0] m16, mf;
    logic [47:0] m8, v16, vf;
    logic [23:0] v8;

    mat_vec_mult_seq #(.SIZE_A(2), .SIZE_B(3), .BITS(16), .FRAC(0)) u16 (
        .clk(clk), .rst_n(rst_n), .in_matrix(m16), .in_vector(v16), .start(start[0]),
        .busy(busy[0]), .out_data(od16), .out_index(out_index[0]), .out_last(out_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sat(out_sat[0]), .done(done[0]));

    mat_vec_mult_seq #(.SIZE_A(2), .SIZE_B(3), .BITS(8), .FRAC(0)) u8 (
        .clk(clk), .rst_n(rst_n), .in_matrix(m8), .in_vector(v8), .start(start[1]),
        .busy(busy[1]), .out_data(od8), .out_index(out_index[1]), .out_last(out_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sat(out_sat[1]), .done(done[1]));

    mat_vec_mult_seq #(.SIZE_A(2), .SIZE_B(3), .BITS(16), .FRAC(1)) uf (
        .clk(clk), .rst_n(rst_n), .in_matrix(mf), .in_vector(vf), .start(start[2]),
        .busy(busy[2]), .out_data(odf), .out_index(out_index[2]), .out_last(out_last[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sat(out_sat[2]), .done(done[2]));

    typedef struct {
        longint data;
        int     idx;
        bit     last;
        bit     sat;
    } exp_t;

    exp_t   exp_q[$];
    longint mm [2][3];
    longint xv [3];
    int     n_pass = 0;
    int     n_total = 0;
    int     active = 0;
    int     done_cnt = 0;
    int     hs_cnt = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint odv(input int d);
        case (d)
            0:       return longint'($signed(od16));
            1:       return longint'($signed(od8));
            default: return longint'($signed(odf));
        endcase
    endfunction

    task automatic load();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                m16[(r*3+c)*16 +: 16] = mm[r][c][15:0];
                mf[(r*3+c)*16 +: 16]  = mm[r][c][15:0];
                m8[(r*3+c)*8 +: 8]    = mm[r][c][7:0];
            end
        end
        for (int c = 0; c < 3; c++) begin
            v16[c*16 +: 16] = xv[c][15:0];
            vf[c*16 +: 16]  = xv[c][15:0];
            v8[c*8 +: 8]    = xv[c][7:0];
        end
    endtask

    // Reference: exact dot product, floor-shift by frac, clamp to the signed range of bits.
    task automatic build(input int bits, input int frac);
        longint s, maxv, minv;
        exp_t e;
        exp_q.delete();
        maxv = (longint'(1) <<< (bits - 1)) - 1;
        minv = -(longint'(1) <<< (bits - 1));
        for (int r = 0; r < 2; r++) begin
            s = 0;
            for (int c = 0; c < 3; c++) s += mm[r][c] * xv[c];
            s = s >>> frac;
            e.sat  = (s > maxv) || (s < minv);
            e.data = (s > maxv) ? maxv : ((s < minv) ? minv : s);
            e.idx  = r;
            e.last = (r == 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (done[d]) begin
                    if (d == active) done_cnt++;
                    else chk("stray_done", 1, 0);
                end
                if (out_valid[d]) begin
                    if (d != active || exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        chk("out_data", odv(d), exp_q[0].data);
                        chk("out_index", longint'(out_index[d]), longint'(exp_q[0].idx));
                        chk("out_last", longint'(out_last[d]), longint'(exp_q[0].last));
                        chk("out_sat", longint'(out_sat[d]), longint'(exp_q[0].sat));
                        if (out_ready[d]) begin
                            void'(exp_q.pop_front());
                            hs_cnt++;
                        end
                    end
                end
            end
        end
    end

    task automatic chk_zero(input string name);
        chk(name, longint'({busy, out_valid, out_last, out_sat, done, out_index}), 0);
        chk({name, "_data"}, longint'({od16, od8, odf}), 0);
    endtask

    task automatic run(input int d, input bit stall, input bit pulse, input int abort_at);
        int n, first_v, done_at, wc;
        active   = d;
        done_cnt = 0;
        hs_cnt   = 0;
        first_v  = -1;
        done_at  = -1;
        wc       = 0;
        out_ready[d] = !stall;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        n = 0;
        chk("busy_after_start", longint'(busy[d]), 1);
        while (n < 200) begin
            if (n == abort_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                exp_q.delete();
                chk_zero("abort_outputs");
                repeat (5) tick();
                chk("abort_no_done", done_cnt, 0);
                chk("abort_idle", longint'(busy[d]), 0);
                return;
            end
            if (out_valid[d] && first_v < 0) first_v = n;
            if (done[d] && done_at < 0) done_at = n;
            if (stall) begin
                if (out_valid[d]) begin
                    if (wc < 5) begin
                        out_ready[d] = 1'b0;
                        wc++;
                    end else begin
                        out_ready[d] = 1'b1;
                        wc = 0;
                    end
                end else begin
                    out_ready[d] = 1'b0;
                end
            end
            start[d] = pulse && (n == 1 || out_valid[d] || done[d]);
            if (done_at >= 0 && n >= done_at + 5) break;
            tick();
            n++;
        end
        start[d] = 1'b0;
        if (done_at < 0) chk("done_timeout", 0, 1);
        chk("done_count", done_cnt, 1);
        chk("handshakes", hs_cnt, 2);
        chk("model_drained", exp_q.size(), 0);
        chk("busy_end", longint'(busy[d]), 0);
        if (!stall) begin
            chk("first_valid_latency", first_v, 4);
            chk("done_latency", done_at, 10);
        end
    endtask

    task automatic set_case1();
        mm[0][0] = 1; mm[0][1] = 2; mm[0][2] = 3;
        mm[1][0] = 4; mm[1][1] = 5; mm[1][2] = 6;
        xv[0] = 1; xv[1] = 1; xv[2] = 1;
        load();
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        out_ready = '0;
        m16 = '0; mf = '0; m8 = '0;
        v16 = '0; vf = '0; v8 = '0;
        repeat (3) tick();
        chk_zero("reset_outputs");
        rst_n = 1'b1;
        tick();

        set_case1();
        build(16, 0);
        chk("model_y0", exp_q[0].data, 6);
        chk("model_y1", exp_q[1].data, 15);
        run(0, 1'b0, 1'b0, -1);

        build(16, 0);
        run(0, 1'b1, 1'b0, -1);

        for (int c = 0; c < 3; c++) begin
            mm[0][c] = 127;
            mm[1][c] = -128;
            xv[c] = 127;
        end
        load();
        build(8, 0);
        chk("model_sat_hi", exp_q[0].data, 127);
        chk("model_sat_lo", exp_q[1].data, -128);
        chk("model_sat_flags", longint'({exp_q[0].sat, exp_q[1].sat}), 3);
        run(1, 1'b0, 1'b0, -1);

        mm[0][0] = -1; mm[0][1] = -1; mm[0][2] = -1;
        mm[1][0] = 3;  mm[1][1] = 0;  mm[1][2] = 0;
        xv[0] = 1; xv[1] = 1; xv[2] = 1;
        load();
        build(16, 1);
        chk("model_frac_y0", exp_q[0].data, -2);
        chk("model_frac_y1", exp_q[1].data, 1);
        run(2, 1'b0, 1'b0, -1);

        set_case1();
        build(16, 0);
        run(0, 1'b0, 1'b0, 6);
        build(16, 0);
        run(0, 1'b0, 1'b0, -1);

        build(16, 0);
        run(0, 1'b0, 1'b1, -1);
        repeat (5) tick();
        chk("restart_ignored", longint'(busy[0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
